// File: rtl/rt_ibex_pcs_ctrl_if.sv
// Frame-memory bus between the PCS sequencer (master) and the frame memory (slave).
// One word per beat: request held until granted, read data returned on a later rvalid.
interface rt_ibex_pcs_ctrl_if #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned AddrWidth = 7
);
    logic                 mem_req_o;
    logic                 mem_we_o;
    logic [AddrWidth-1:0] mem_addr_o;
    logic [DataWidth-1:0] mem_wdata_o;
    logic                 mem_gnt_i;
    logic                 mem_rvalid_i;
    logic [DataWidth-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/rt_ibex_pcs_ctrl.sv
// PCS frame spill/fill sequencer. Snapshots the saved-register frame on PCS interrupt
// entry and writes it serially to the frame memory; on mret reads the top frame back
// and presents it with a one-cycle restore strobe. One push may be parked while busy.
// Optional performance counters: define RT_IBEX_PCS_CTRL_PERF_EN.
module rt_ibex_pcs_ctrl #(
    parameter int unsigned NrSavedRegs   = 18,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned Depth         = 4,
    parameter int unsigned IrqLevelWidth = 8,
    localparam int unsigned FrameW    = NrSavedRegs * DataWidth,
    localparam int unsigned AddrWidth = $clog2(Depth * NrSavedRegs),
    localparam int unsigned DepthW    = $clog2(Depth + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     irq_ack_i,
    input  logic                     irq_is_pcs_i,
    input  logic [IrqLevelWidth-1:0] irq_level_i,
    input  logic                     next_mret_i,
    input  logic [FrameW-1:0]        frame_i,
    output logic [FrameW-1:0]        frame_o,
    output logic                     restore_en_o,
    output logic                     busy_o,
    rt_ibex_pcs_ctrl_if.master       mem,
    output logic [DepthW-1:0]        depth_o,
    output logic [IrqLevelWidth-1:0] level_o,
    output logic                     overflow_o,
    output logic [15:0]              perf_saves_o,
    output logic [15:0]              perf_stall_o
);
    localparam int unsigned BeatW   = $clog2(NrSavedRegs);
    localparam int unsigned LvlIdxW = $clog2(Depth);

    typedef enum logic [2:0] {S_IDLE, S_SAVE, S_RD_REQ, S_RD_WAIT, S_DONE} state_e;

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [BeatW-1:0]         r_beat;
    logic [DepthW-1:0]        r_depth;
    logic [IrqLevelWidth-1:0] r_lvl_stack [Depth];
    logic [FrameW-1:0]        r_save_buf;
    logic [IrqLevelWidth-1:0] r_save_lvl;
    logic [FrameW-1:0]        r_pend_frame;
    logic [IrqLevelWidth-1:0] r_pend_lvl;
    logic                     r_pend_vld;
    logic                     r_overflow;
    logic [FrameW-1:0]        r_frame;

    logic                     w_push;
    logic                     w_pop;
    logic                     w_room;
    logic                     w_last_beat;
    logic                     w_save_done;
    logic [DepthW-1:0]        w_slot;
    logic [LvlIdxW-1:0]       w_top_idx;
    logic [LvlIdxW-1:0]       w_wr_idx;

    assign w_push      = irq_ack_i & irq_is_pcs_i;
    assign w_pop       = next_mret_i & (r_depth != '0);
    assign w_room      = (r_depth < DepthW'(Depth));
    assign w_last_beat = (r_beat == BeatW'(NrSavedRegs - 1));
    assign w_save_done = (r_state == S_SAVE) & mem.mem_gnt_i & w_last_beat;
    // Saves target the next free slot, reads the current top slot.
    assign w_slot      = (r_state == S_SAVE) ? r_depth : (r_depth - DepthW'(1));
    assign w_top_idx   = LvlIdxW'(r_depth - DepthW'(1));
    assign w_wr_idx    = LvlIdxW'(r_depth);

    assign frame_o    = r_frame;
    assign depth_o    = r_depth;
    assign overflow_o = r_overflow;
    assign level_o    = (r_depth == '0) ? '0 : r_lvl_stack[w_top_idx];

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and bus outputs; address/data held constant while a request waits for grant.
    always_comb begin
        w_state_nxt      = r_state;
        busy_o           = (r_state != S_IDLE);
        restore_en_o     = 1'b0;
        mem.mem_req_o    = 1'b0;
        mem.mem_we_o     = 1'b0;
        mem.mem_addr_o   = '0;
        mem.mem_wdata_o  = '0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld) begin
                    if (w_room) w_state_nxt = S_SAVE;
                end else if (w_push) begin
                    if (w_room) w_state_nxt = S_SAVE;
                end else if (w_pop) begin
                    w_state_nxt = S_RD_REQ;
                end
            end
            S_SAVE: begin
                mem.mem_req_o   = 1'b1;
                mem.mem_we_o    = 1'b1;
                mem.mem_addr_o  = AddrWidth'(w_slot) * AddrWidth'(NrSavedRegs) + AddrWidth'(r_beat);
                mem.mem_wdata_o = r_save_buf[r_beat*DataWidth +: DataWidth];
                if (w_save_done) w_state_nxt = S_IDLE;
            end
            S_RD_REQ: begin
                mem.mem_req_o  = 1'b1;
                mem.mem_addr_o = AddrWidth'(w_slot) * AddrWidth'(NrSavedRegs) + AddrWidth'(r_beat);
                if (mem.mem_gnt_i) w_state_nxt = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem.mem_rvalid_i) w_state_nxt = w_last_beat ? S_DONE : S_RD_REQ;
            end
            S_DONE: begin
                restore_en_o = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Beat counter, depth/level stack, beat buffers, pending slot and sticky overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beat     <= '0;
            r_depth    <= '0;
            r_pend_vld <= 1'b0;
            r_overflow <= 1'b0;
            r_frame    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_beat <= '0;
                    if (r_pend_vld) begin
                        if (w_room) begin
                            r_save_buf <= r_pend_frame;
                            r_save_lvl <= r_pend_lvl;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end else if (w_push) begin
                        if (w_room) begin
                            r_save_buf <= frame_i;
                            r_save_lvl <= irq_level_i;
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                end
                S_SAVE: begin
                    if (w_save_done) begin
                        r_depth               <= r_depth + DepthW'(1);
                        r_lvl_stack[w_wr_idx] <= r_save_lvl;
                        r_beat                <= '0;
                    end else if (mem.mem_gnt_i) begin
                        r_beat <= r_beat + BeatW'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (mem.mem_rvalid_i) begin
                        r_frame[r_beat*DataWidth +: DataWidth] <= mem.mem_rdata_i;
                        if (!w_last_beat) r_beat <= r_beat + BeatW'(1);
                    end
                end
                S_DONE: begin
                    r_depth <= r_depth - DepthW'(1);
                    r_beat  <= '0;
                end
                default: ;
            endcase

            // A push that cannot start now is parked; the slot is drained from IDLE.
            if (r_state == S_IDLE) begin
                if (r_pend_vld) begin
                    r_pend_vld <= w_push;
                    if (w_push) begin
                        r_pend_frame <= frame_i;
                        r_pend_lvl   <= irq_level_i;
                    end
                end
            end else if (w_push) begin
                if (r_pend_vld) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_pend_vld   <= 1'b1;
                    r_pend_frame <= frame_i;
                    r_pend_lvl   <= irq_level_i;
                end
            end
        end
    end

`ifdef RT_IBEX_PCS_CTRL_PERF_EN
    logic [15:0] r_perf_saves;
    logic [15:0] r_perf_stall;

    // Saturating save and stall counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_saves <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_save_done && (r_perf_saves != 16'hFFFF)) r_perf_saves <= r_perf_saves + 16'd1;
            if (busy_o && (r_perf_stall != 16'hFFFF))      r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    assign perf_saves_o = r_perf_saves;
    assign perf_stall_o = r_perf_stall;
`else
    assign perf_saves_o = '0;
    assign perf_stall_o = '0;
`endif
endmodule

// File: tb/tb_rt_ibex_pcs_ctrl.sv
// Bench for rt_ibex_pcs_ctrl: table of push/pop operations with expected depth, level,
// overflow and busy duration, a memory-transaction/restore scoreboard, and hand-written
// sequences for grant stalls, pending push during restore and reset mid-save.
module tb_rt_ibex_pcs_ctrl;
    localparam int NR  = 18;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int LW  = 8;
    localparam int FW  = NR * DW;
    localparam int AW  = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          irq_ack = 1'b0;
    logic          irq_is_pcs = 1'b0;
    logic [LW-1:0] irq_level = '0;
    logic          next_mret = 1'b0;
    logic [FW-1:0] frame_in = '0;
    logic [FW-1:0] frame_out;
    logic          restore_en;
    logic          busy;
    logic [2:0]    depth;
    logic [LW-1:0] level;
    logic          overflow;
    logic [15:0]   perf_saves;
    logic [15:0]   perf_stall;
    logic          gnt = 1'b1;
    logic          rvalid_q = 1'b0;
    logic [DW-1:0] rdata_q = '0;
    logic [DW-1:0] mem_arr [DEP*NR];

    always #5 clk = ~clk;

    rt_ibex_pcs_ctrl_if #(.DataWidth(DW), .AddrWidth(AW)) mem_if ();
    assign mem_if.mem_gnt_i    = gnt;
    assign mem_if.mem_rvalid_i = rvalid_q;
    assign mem_if.mem_rdata_i  = rdata_q;

    rt_ibex_pcs_ctrl #(.NrSavedRegs(NR), .DataWidth(DW), .Depth(DEP), .IrqLevelWidth(LW)) dut (
        .clk_i(clk), .rst_i(rst), .irq_ack_i(irq_ack), .irq_is_pcs_i(irq_is_pcs),
        .irq_level_i(irq_level), .next_mret_i(next_mret), .frame_i(frame_in),
        .frame_o(frame_out), .restore_en_o(restore_en), .busy_o(busy), .mem(mem_if),
        .depth_o(depth), .level_o(level), .overflow_o(overflow),
        .perf_saves_o(perf_saves), .perf_stall_o(perf_stall)
    );

    // Frame memory: writes land on grant, read data returns the cycle after grant.
    always @(posedge clk) begin
        rvalid_q <= mem_if.mem_req_o & gnt & ~mem_if.mem_we_o;
        rdata_q  <= mem_arr[mem_if.mem_addr_o];
        if (mem_if.mem_req_o && gnt && mem_if.mem_we_o) mem_arr[mem_if.mem_addr_o] <= mem_if.mem_wdata_o;
    end

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } tx_t;
    typedef struct {
        logic push; logic pop; logic [LW-1:0] lvl; logic [31:0] base;
        int exp_cyc; logic [2:0] exp_depth; logic [LW-1:0] exp_level; logic exp_ov;
    } vec_t;

    tx_t           wq[$];
    logic [FW-1:0] rq[$];
    logic [FW-1:0] m_frames [DEP];
    int            m_depth = 0;
    int            n_chk = 0;
    int            n_pass = 0;
    logic          sb_en = 1'b0;
    vec_t          vt [12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    function automatic logic [FW-1:0] mkframe(input logic [31:0] base);
        logic [FW-1:0] f;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = base + 32'(i);
        return f;
    endfunction

    task automatic model_push(input logic [31:0] base);
        if (m_depth < DEP) begin
            for (int i = 0; i < NR; i++) wq.push_back('{we: 1'b1, addr: AW'(m_depth*NR + i), data: base + 32'(i)});
            m_frames[m_depth] = mkframe(base);
            m_depth++;
        end
    endtask

    task automatic model_pop();
        if (m_depth > 0) begin
            m_depth--;
            for (int i = 0; i < NR; i++) wq.push_back('{we: 1'b0, addr: AW'(m_depth*NR + i), data: '0});
            rq.push_back(m_frames[m_depth]);
        end
    endtask

    // Scoreboard monitor, sampling just before each rising edge.
    always @(negedge clk) begin
        tx_t           t;
        logic [FW-1:0] f;
        logic [DW-1:0] wd;
        #4;
        if (sb_en && mem_if.mem_req_o && gnt) begin
            if (wq.size() == 0) begin
                chk("sb_unexpected_req", 64'({mem_if.mem_we_o, mem_if.mem_addr_o}), 64'hDEAD);
            end else begin
                t  = wq.pop_front();
                wd = mem_if.mem_we_o ? mem_if.mem_wdata_o : '0;
                chk("sb_tx", 64'({mem_if.mem_we_o, mem_if.mem_addr_o, wd}), 64'({t.we, t.addr, t.data}));
            end
        end
        if (sb_en && restore_en) begin
            n_chk++;
            if (rq.size() == 0) begin
                $display("FAIL restore_unexpected: got word0 0x%0h expected no restore", frame_out[DW-1:0]);
            end else begin
                f = rq.pop_front();
                if (frame_out === f) n_pass++;
                else $display("FAIL restore_frame: got w0/w17 0x%0h/0x%0h expected 0x%0h/0x%0h",
                              frame_out[DW-1:0], frame_out[FW-1 -: DW], f[DW-1:0], f[FW-1 -: DW]);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic push, input logic pop, input logic [LW-1:0] lvl, input logic [31:0] base);
        irq_ack = push; irq_is_pcs = push; next_mret = pop; irq_level = lvl; frame_in = mkframe(base);
    endtask

    task automatic release_in();
        irq_ack = 1'b0; irq_is_pcs = 1'b0; next_mret = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
            if (cyc == 1) release_in();
        end while (busy && cyc < budget);
        if (busy) chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while ((busy || wq.size() != 0 || rq.size() != 0) && c < budget) begin
            step();
            c++;
        end
        chk("drain", 64'(wq.size() + rq.size()) + 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int  cyc;
        logic found;
        vt[0]  = '{1'b1, 1'b0, 8'd1, 32'h100,  19, 3'd1, 8'd1, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 8'd0, 32'h0,    38, 3'd0, 8'd0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 8'd1, 32'h1000, 19, 3'd1, 8'd1, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 8'd2, 32'h2000, 19, 3'd2, 8'd2, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 8'd3, 32'h3000, 19, 3'd3, 8'd3, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 8'd4, 32'h4000, 19, 3'd4, 8'd4, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 8'd5, 32'h5000,  1, 3'd4, 8'd4, 1'b1};
        vt[7]  = '{1'b0, 1'b1, 8'd0, 32'h0,    38, 3'd3, 8'd3, 1'b1};
        vt[8]  = '{1'b0, 1'b1, 8'd0, 32'h0,    38, 3'd2, 8'd2, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 8'd0, 32'h0,    38, 3'd1, 8'd1, 1'b1};
        vt[10] = '{1'b0, 1'b1, 8'd0, 32'h0,    38, 3'd0, 8'd0, 1'b1};
        vt[11] = '{1'b0, 1'b1, 8'd0, 32'h0,     1, 3'd0, 8'd0, 1'b1};

        // Reset values
        step(); step();
        chk("rst_depth", 64'(depth), 64'(0));
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_restore_en", 64'(restore_en), 64'(0));
        chk("rst_req_we", 64'({mem_if.mem_req_o, mem_if.mem_we_o}), 64'(0));
        chk("rst_addr_wdata", 64'({mem_if.mem_addr_o, mem_if.mem_wdata_o}), 64'(0));
        chk("rst_frame_w0", 64'(frame_out[DW-1:0]), 64'(0));
        chk("rst_perf", 64'({perf_saves, perf_stall}), 64'(0));
        rst = 1'b0;
        sb_en = 1'b1;

        // Table of push/pop operations
        for (int r = 0; r < 12; r++) begin
            drive(vt[r].push, vt[r].pop, vt[r].lvl, vt[r].base);
            if (vt[r].push) model_push(vt[r].base);
            else if (vt[r].pop) model_pop();
            run_until_idle(100, cyc);
            chk($sformatf("row%0d_cycles", r), 64'(cyc), 64'(vt[r].exp_cyc));
            chk($sformatf("row%0d_depth", r), 64'(depth), 64'(vt[r].exp_depth));
            chk($sformatf("row%0d_level", r), 64'(level), 64'(vt[r].exp_level));
            chk($sformatf("row%0d_overflow", r), 64'(overflow), 64'(vt[r].exp_ov));
            chk($sformatf("row%0d_sb_empty", r), 64'(wq.size() + rq.size()), 64'(0));
        end

        // Reset clears sticky overflow
        rst = 1'b1; step(); step(); rst = 1'b0;
        m_depth = 0;
        chk("rst2_overflow", 64'(overflow), 64'(0));
        chk("rst2_depth", 64'(depth), 64'(0));

        // Grant held low for 3 cycles on beat 5 of a save
        drive(1'b1, 1'b0, 8'd6, 32'h6000);
        model_push(32'h6000);
        cyc = 0; found = 1'b0;
        do begin
            step();
            cyc++;
            if (cyc == 1) release_in();
            if (!found && mem_if.mem_req_o && mem_if.mem_addr_o == AW'(5)) begin
                found = 1'b1;
                gnt = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    cyc++;
                    chk("stall_req", 64'({mem_if.mem_req_o, mem_if.mem_we_o}), 64'(3));
                    chk("stall_addr", 64'(mem_if.mem_addr_o), 64'(5));
                    chk("stall_wdata", 64'(mem_if.mem_wdata_o), 64'h6005);
                end
                gnt = 1'b1;
            end
        end while (busy && cyc < 100);
        chk("stall_seen", 64'(found), 64'(1));
        chk("stall_cycles", 64'(cyc), 64'(22));
        chk("stall_depth", 64'(depth), 64'(1));

        // Push during restore parks in the pending slot; a second push overflows
        drive(1'b0, 1'b1, 8'd0, 32'h0);
        model_pop();
        step(); release_in();
        step(); step();
        drive(1'b1, 1'b0, 8'd7, 32'h7000);
        model_push(32'h7000);
        step(); release_in();
        chk("pend_overflow_clear", 64'(overflow), 64'(0));
        step();
        drive(1'b1, 1'b0, 8'd8, 32'h8000);
        step(); release_in();
        chk("pend_overflow_set", 64'(overflow), 64'(1));
        chk("pend_busy", 64'(busy), 64'(1));
        drain(200);
        chk("pend_depth", 64'(depth), 64'(1));
        chk("pend_level", 64'(level), 64'(7));

        // Reset in the middle of a save (beat 9)
        drive(1'b1, 1'b0, 8'd9, 32'h9000);
        model_push(32'h9000);
        cyc = 0; found = 1'b0;
        while (!found && cyc < 50) begin
            step();
            cyc++;
            if (cyc == 1) release_in();
            if (mem_if.mem_req_o && mem_if.mem_addr_o == AW'(NR + 9)) found = 1'b1;
        end
        chk("midsave_beat9_seen", 64'(found), 64'(1));
        chk("midsave_wdata", 64'(mem_if.mem_wdata_o), 64'h9009);
        sb_en = 1'b0;
        rst = 1'b1;
        step();
        chk("midsave_req", 64'(mem_if.mem_req_o), 64'(0));
        chk("midsave_depth", 64'(depth), 64'(0));
        chk("midsave_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        wq.delete(); rq.delete(); m_depth = 0;
        step(); step();
        chk("post_rst_idle", 64'({busy, mem_if.mem_req_o}), 64'(0));

`ifndef RT_IBEX_PCS_CTRL_PERF_EN
        chk("perf_tied_zero", 64'({perf_saves, perf_stall}), 64'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
